// File: rtl/sqrt_csr_slave.sv
`default_nettype none
// sqrt_csr_slave - bus-mapped iterative 32-bit integer square root with an operand FIFO.
// Revision: 1.0
module sqrt_csr_slave #(
  parameter logic [31:0] BASE_ADDR      = 32'h80001000,
  parameter int          FIFO_DEPTH_POW = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        busy_o,
  output logic        done_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_POW;
  localparam int CW    = FIFO_DEPTH_POW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  localparam logic [1:0] REG_OPERAND = 2'd0;
  localparam logic [1:0] REG_RESULT  = 2'd1;
  localparam logic [1:0] REG_REM     = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // bus decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_acc;
  logic       rd_acc;
  logic       soft_clr;
  logic       push;
  logic       pop;
  logic       rd_result;

  // operand fifo
  logic [31:0]               mem [DEPTH];
  logic [FIFO_DEPTH_POW-1:0] wr_ptr;
  logic [FIFO_DEPTH_POW-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [31:0]               fifo_out;

  // engine
  logic [0:0]  state;
  logic [31:0] rad;
  logic [17:0] rem;
  logic [15:0] root;
  logic [3:0]  iter;
  logic [17:0] rem_sh;
  logic [17:0] trial;
  logic [17:0] rem_nx;
  logic [15:0] root_nx;
  logic        ge;
  logic        commit;

  // architectural registers
  logic [15:0] result;
  logic [16:0] remainder;
  logic [31:0] last_op;
  logic        done;
  logic [31:0] status;
  logic [31:0] rdata_mux;
  logic        resp;
  logic [31:0] rdata;

  logic unused_ok;
  assign unused_ok = ^{bus_be_bi, bus_addr_bi[1:0], rem[17:16]};

  assign hit      = bus_req_i && (bus_addr_bi[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = bus_addr_bi[3:2];
  // A full FIFO stalls pushes even when a pop lands in the same cycle.
  assign bus_ack_o = rst_ni && hit && !(bus_we_i && (reg_sel == REG_OPERAND) && fifo_full);

  assign wr_acc    = bus_ack_o && bus_we_i;
  assign rd_acc    = bus_ack_o && !bus_we_i;
  assign soft_clr  = wr_acc && (reg_sel == REG_STATUS) && bus_wdata_bi[0];
  assign push      = wr_acc && (reg_sel == REG_OPERAND) && !soft_clr;
  assign rd_result = rd_acc && (reg_sel == REG_RESULT);

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign fifo_out   = mem[rd_ptr];
  assign pop        = (state == ST_IDLE) && !fifo_empty && !soft_clr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus_wdata_bi;
  end

  // One result bit per cycle: bring down the next two radicand bits and try 4*root+1.
  always_comb begin
    rem_sh  = {rem[15:0], rad[31:30]};
    trial   = {root, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = {root[14:0], ge};
  end

  assign commit = (state == ST_CALC) && (iter == 4'd0) && !soft_clr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      iter      <= '0;
      result    <= '0;
      remainder <= '0;
      last_op   <= '0;
    end else if (soft_clr) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            rad     <= fifo_out;
            rem     <= '0;
            root    <= '0;
            iter    <= 4'd15;
            last_op <= fifo_out;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rad  <= {rad[29:0], 2'b00};
          rem  <= rem_nx;
          root <= root_nx;
          iter <= iter - 4'd1;
          if (iter == 4'd0) begin
            result    <= root_nx;
            remainder <= rem_nx[16:0];
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new result beats a concurrent RESULT read, so done stays set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done <= 1'b0;
    end else if (commit) begin
      done <= 1'b1;
    end else if (soft_clr || rd_result) begin
      done <= 1'b0;
    end
  end

  assign busy_o = (state == ST_CALC);
  assign done_o = done;
  assign status = {20'b0, 8'(count), fifo_empty, fifo_full, done, busy_o};

  always_comb begin
    rdata_mux = '0;
    case (reg_sel)
      REG_OPERAND: rdata_mux = last_op;
      REG_RESULT:  rdata_mux = {16'b0, result};
      REG_REM:     rdata_mux = {15'b0, remainder};
      REG_STATUS:  rdata_mux = status;
      default:     rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      resp  <= rd_acc;
      rdata <= rd_acc ? rdata_mux : 32'd0;
    end
  end

  assign bus_resp_o   = resp;
  assign bus_rdata_bo = rdata;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_csr_slave.sv
`default_nettype none
// tb_sqrt_csr_slave - table-driven and randomized self-checking bench for sqrt_csr_slave.
// Revision: 1.0
`timescale 1ns/1ps
module tb_sqrt_csr_slave;

  localparam logic [31:0] BASE   = 32'h80001000;
  localparam logic [31:0] A_OP   = BASE + 32'h0;
  localparam logic [31:0] A_RES  = BASE + 32'h4;
  localparam logic [31:0] A_REM  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        bus_req_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic [31:0] bus_addr_bi = '0;
  logic [3:0]  bus_be_bi = 4'hF;
  logic [31:0] bus_wdata_bi = '0;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  sqrt_csr_slave dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus_req_i    (bus_req_i),
    .bus_we_i     (bus_we_i),
    .bus_addr_bi  (bus_addr_bi),
    .bus_be_bi    (bus_be_bi),
    .bus_wdata_bi (bus_wdata_bi),
    .bus_ack_o    (bus_ack_o),
    .bus_resp_o   (bus_resp_o),
    .bus_rdata_bo (bus_rdata_bo),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] root;
    logic [31:0] rem;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] q[$];

  // Reference: largest r with r*r <= x, found by bisection on plain integers.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
    bus_req_i = 1'b1;
    bus_we_i = 1'b1;
    bus_addr_bi = addr;
    bus_wdata_bi = data;
    stalls = 0;
    #1;
    while (!bus_ack_o && stalls < 200) begin
      tick();
      #1;
      stalls++;
    end
    if (!bus_ack_o) begin
      checks++;
      failures++;
      $display("FAIL write_ack_timeout: addr 0x%08h got no ack, expected ack", addr);
    end
    tick();
    bus_req_i = 1'b0;
    bus_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    int s;
    bus_write(addr, data, s);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    bus_req_i = 1'b1;
    bus_we_i = 1'b0;
    bus_addr_bi = addr;
    data = '0;
    #1;
    while (!bus_ack_o && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (!bus_ack_o) begin
      checks++;
      failures++;
      $display("FAIL read_ack_timeout: addr 0x%08h got no ack, expected ack", addr);
      bus_req_i = 1'b0;
      tick();
      return;
    end
    tick();
    bus_req_i = 1'b0;
    check("read_resp", 32'(bus_resp_o), 32'd1);
    data = bus_rdata_bo;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_o && cycles < 300) begin
      tick();
      cycles++;
    end
    if (!done_o) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: done_o stayed 0, expected 1");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]     d;
    logic [31:0]     op;
    logic [31:0]     r;
    longint unsigned er;
    int              n;
    int              stalls;

    vecs[0] = '{32'h00000090, 32'h0000000C, 32'h00000000};
    vecs[1] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h0001FFFE};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'h00000002, 32'h00000001, 32'h00000001};
    vecs[4] = '{32'h00000001, 32'h00000001, 32'h00000000};
    vecs[5] = '{32'h00000008, 32'h00000002, 32'h00000004};
    vecs[6] = '{32'h40000000, 32'h00008000, 32'h00000000};
    vecs[7] = '{32'h00000063, 32'h00000009, 32'h00000012};

    // reset state, with an in-window request held during reset
    bus_req_i = 1'b1;
    bus_addr_bi = A_STAT;
    #2;
    check("rst_ack", 32'(bus_ack_o), 32'd0);
    check("rst_resp", 32'(bus_resp_o), 32'd0);
    check("rst_rdata", bus_rdata_bo, 32'd0);
    check("rst_busy_done", 32'({busy_o, done_o}), 32'd0);
    bus_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    bus_read(A_STAT, d);
    check("status_after_reset", d, 32'h00000008);
    tick();
    check("resp_one_cycle", 32'(bus_resp_o), 32'd0);
    check("rdata_zero_idle", bus_rdata_bo, 32'd0);

    // latency from push acceptance to done
    wr(A_OP, 32'h90);
    wait_done(n);
    check("done_latency", 32'(n), 32'd17);
    bus_read(A_RES, d);
    check("latency_result", d, 32'h0000000C);
    bus_read(A_REM, d);
    check("latency_rem", d, 32'd0);
    bus_read(A_STAT, d);
    check("done_cleared_by_read", 32'(d[1]), 32'd0);

    // directed vectors
    foreach (vecs[i]) begin
      wr(A_OP, vecs[i].op);
      wait_done(n);
      bus_read(A_RES, d);
      check($sformatf("vec%0d_result", i), d, vecs[i].root);
      bus_read(A_REM, d);
      check($sformatf("vec%0d_rem", i), d, vecs[i].rem);
      bus_read(A_OP, d);
      check($sformatf("vec%0d_lastop", i), d, vecs[i].op);
    end

    // random back-to-back pairs against the reference
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: op = $urandom;
          1: op = $urandom_range(0, 1000);
          2: begin
            r = $urandom_range(0, 65535);
            op = r * r;
          end
          default: op = $urandom | 32'hC0000000;
        endcase
        q.push_back(op);
        wr(A_OP, op);
      end
      for (int k = 0; k < 2; k++) begin
        wait_done(n);
        op = q.pop_front();
        er = isqrt(longint'(op));
        bus_read(A_RES, d);
        check($sformatf("rnd%0d_%0d_result(op=%08h)", it, k, op), d, 32'(er));
        bus_read(A_REM, d);
        check($sformatf("rnd%0d_%0d_rem(op=%08h)", it, k, op), d, 32'(longint'(op) - er * er));
      end
      bus_read(A_OP, d);
      check($sformatf("rnd%0d_lastop", it), d, op);
    end

    // FIFO full: engine busy on the first operand, four more fill the queue
    wr(A_OP, 32'd1000000);
    for (int k = 0; k < 4; k++) wr(A_OP, 32'd100 + 32'(k));
    bus_read(A_STAT, d);
    check("status_full", d, 32'h00000045);
    bus_write(A_OP, 32'd7, stalls);
    check("push_stalled_when_full", 32'(stalls > 0), 32'd1);
    bus_read(A_RES, d);
    check("full_first_result", d, 32'd1000);
    bus_read(A_STAT, d);
    check("status_full_again", d & 32'h00000FFC, 32'h00000044);
    wr(A_STAT, 32'd1);
    bus_read(A_STAT, d);
    check("status_after_flush", d, 32'h00000008);

    // soft clear five cycles into CALC with two operands queued
    wr(A_OP, 32'h90);
    wr(A_OP, 32'd50);
    wr(A_OP, 32'd60);
    repeat (3) tick();
    check("busy_before_clear", 32'(busy_o), 32'd1);
    wr(A_STAT, 32'd1);
    check("clear_busy", 32'(busy_o), 32'd0);
    check("clear_done", 32'(done_o), 32'd0);
    bus_read(A_STAT, d);
    check("clear_status", d, 32'h00000008);
    bus_read(A_RES, d);
    check("clear_result_kept", d, 32'd1000);
    repeat (20) tick();
    check("clear_no_commit", 32'({busy_o, done_o}), 32'd0);

    // writes to RESULT are ignored
    wr(A_RES, 32'hDEAD);
    bus_read(A_RES, d);
    check("result_write_ignored", d, 32'd1000);

    // out-of-window read
    bus_req_i = 1'b1;
    bus_we_i = 1'b0;
    bus_addr_bi = 32'h80002000;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus_ack_o) n++;
      tick();
      if (bus_resp_o || bus_rdata_bo != 32'd0) n++;
    end
    bus_req_i = 1'b0;
    check("outside_window_ignored", 32'(n), 32'd0);
    bus_read(A_OP, d);
    check("lastop_after_clear", d, 32'h90);

    // async reset mid-CALC
    wr(A_OP, 32'hFFFFFFFF);
    repeat (6) tick();
    check("busy_before_reset", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("async_rst_outputs", 32'({bus_ack_o, bus_resp_o, busy_o, done_o}), 32'd0);
    check("async_rst_rdata", bus_rdata_bo, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    bus_read(A_STAT, d);
    check("reset_status", d, 32'h00000008);
    bus_read(A_RES, d);
    check("reset_result", d, 32'd0);
    bus_read(A_REM, d);
    check("reset_rem", d, 32'd0);
    bus_read(A_OP, d);
    check("reset_lastop", d, 32'd0);
    repeat (20) tick();
    check("reset_no_commit", 32'(done_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
